fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Sequences instruction fetch around the program-counter register. It computes the PC register's next-address input every cycle, choosing between hold, sequential, redirect and trap. It runs the request/response handshake with instruction memory and presents fetched instructions to decode through a one-entry valid/ready buffer. It sits between the PC register, instruction memory, and the decode and branch/trap units.

Parameters:
ADDR_WIDTH_POW, 6, log2 of address width; ADDR_WIDTH = 1 << ADDR_WIDTH_POW (localparam)
RESET_VECTOR, 0, PC value driven while in reset and after reset release
INSTR_BYTES, 4, sequential PC increment

Ports:
clk_in  input  1  clock
reset  input  1  asynchronous, active-low reset
run_in  input  1  enables fetching; low parks the FSM in IDLE after any outstanding response
stall_in  input  1  hold PC; no new request issued
redirect_valid  input  1  branch/jump taken
redirect_addr  input  ADDR_WIDTH  branch/jump target
trap_valid  input  1  trap/exception taken
trap_vector  input  ADDR_WIDTH  trap handler address
pc_cur_in  input  ADDR_WIDTH  current PC (PC register output)
pc_next_out  output  ADDR_WIDTH  next PC (PC register input)
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_WIDTH  fetch address (= pc_cur_in)
imem_resp_valid  input  1  response data valid
imem_resp_data  input  32  fetched instruction
instr_valid  output  1  buffered instruction valid
instr_ready  input  1  decode accepts
instr_data  output  32  buffered instruction
instr_pc  output  ADDR_WIDTH  PC of buffered instruction
fetch_count  output  32  count of instructions delivered to decode

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM = IDLE, instr_valid = 0, instr_data = 0, instr_pc = 0, fetch_count = 0, imem_req_valid = 0.
  - pc_next_out = RESET_VECTOR while in reset and while in IDLE with no redirect or trap.
- FSM states: IDLE, REQ, WAIT, DROP.
- IDLE:
  - pc_next_out = pc_cur_in (hold), except the reset case above.
  - Go to REQ when run_in = 1.
- REQ:
  - imem_req_valid = !stall_in && (!instr_valid || instr_ready).
  - imem_req_addr = pc_cur_in.
  - On valid && ready, go to WAIT. pc_next_out holds.
- WAIT:
  - On imem_resp_valid: instr_data <= resp, instr_pc <= pc_cur_in, instr_valid <= 1, pc_next_out = pc_cur_in + INSTR_BYTES.
  - Next state is REQ if run_in = 1, else IDLE.
  - The response always fits: a request is only issued when the buffer will be free.
- DROP:
  - Wait for imem_resp_valid, discard the data, go to REQ (IDLE if run_in = 0).
  - pc_next_out holds.
- Next-PC priority, evaluated every cycle in every state: trap > redirect > sequential (WAIT response only) > hold.
- Trap or redirect in any state:
  - pc_next_out = target.
  - Output buffer flushed: instr_valid <= 0; decode must not consume in that cycle.
  - If a request is outstanding (WAIT, or REQ with the handshake completing this cycle), go to DROP; otherwise go to REQ.
  - A redirect coincident with a WAIT response: the response is discarded, go to REQ.
- Request stability:
  - While in REQ, imem_req_addr and imem_req_valid may change only due to redirect, trap or stall (request not yet accepted).
  - Memory must not latch a request without ready.
- Buffer: instr_valid clears on instr_ready && !capture; stays set on simultaneous drain and capture.
- Stall: stall_in has no effect in WAIT or DROP; the response is still captured or discarded.
- fetch_count increments on instr_valid && instr_ready && !flush and wraps at 2^32.
- Widths: all PC arithmetic is ADDR_WIDTH, modulo 2^ADDR_WIDTH; the top-of-space increment wraps to 0.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum (IDLE, REQ, WAIT, DROP)
  - INSTR_WIDTH = 32
  - next_pc_sel_t enum (HOLD, SEQ, REDIRECT, TRAP)
- One sub-module, next_pc_mux: combinational priority select of pc_next_out.
- FSM, buffer and counter stay in fetch_sequencer.

Test Plan:
- Reset release, run_in = 1, imem_req_ready = 1, 1-cycle response latency:
  - imem_req_addr = 0, 4, 8.
  - instr_pc matches each address.
  - fetch_count = 3 after 3 accepts.
- Decode back-pressure, instr_ready = 0 with buffer full:
  - imem_req_valid = 0.
  - pc_next_out holds at 0x4.
  - Release → request to 0x4 issues next cycle.
- redirect_valid with redirect_addr = 0x100 while in WAIT:
  - FSM → DROP; the pending response is discarded, not delivered.
  - Next request address = 0x100.
- trap_valid (vector 0x200) and redirect_valid (0x100) in the same cycle:
  - pc_next_out = 0x200.
  - instr_valid = 0 next cycle.
- stall_in = 1 in REQ for 5 cycles:
  - no imem_req_valid.
  - PC unchanged.
  - fetch resumes at the same address after release.
- reset asserted asynchronously mid-WAIT:
  - all outputs reach reset values immediately.
  - the late response is ignored.
  - first post-release request address = RESET_VECTOR.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Latency: none, declarations only.
// Backpressure: not applicable.
package fetch_pkg;

    localparam int INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        SEQ      = 2'd1,
        REDIRECT = 2'd2,
        TRAP     = 2'd3
    } next_pc_sel_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory request/response and decode-side valid/ready bundle.
// Latency: wires only.
// Backpressure: imem_req_ready and instr_ready flow from slave to master.
interface fetch_sequencer_if
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 64
);
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [ADDR_WIDTH-1:0]  imem_req_addr;
    logic                   imem_resp_valid;
    logic [INSTR_WIDTH-1:0] imem_resp_data;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr_data;
    logic [ADDR_WIDTH-1:0]  instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_sequencer_next_pc_mux.sv
// Priority select of the PC register's next value: trap > redirect > sequential > hold.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module next_pc_mux
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_BYTES = 4
) (
    input  logic                  trap_valid,
    input  logic [ADDR_WIDTH-1:0] trap_vector,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  seq_en,
    input  logic [ADDR_WIDTH-1:0] pc_cur,
    input  logic [ADDR_WIDTH-1:0] hold_addr,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output next_pc_sel_t          sel
);

    // Highest-priority source wins; sequential add wraps modulo the address space.
    always_comb begin
        sel     = HOLD;
        pc_next = hold_addr;
        if (trap_valid) begin
            sel     = TRAP;
            pc_next = trap_vector;
        end else if (redirect_valid) begin
            sel     = REDIRECT;
            pc_next = redirect_addr;
        end else if (seq_en) begin
            sel     = SEQ;
            pc_next = pc_cur + ADDR_WIDTH'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch FSM driving the PC register's next address, the imem handshake and a one-entry decode buffer.
// Latency: one request in flight; response lands in the buffer the cycle after it is seen.
// Backpressure: no request issues unless the buffer is empty or draining, and never under stall.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                              ADDR_WIDTH_POW = 6,
    parameter logic [(1<<ADDR_WIDTH_POW)-1:0] RESET_VECTOR   = '0,
    parameter int                              INSTR_BYTES    = 4
) (
    input  logic                           clk_in,
    input  logic                           reset,
    input  logic                           run_in,
    input  logic                           stall_in,
    input  logic                           redirect_valid,
    input  logic [(1<<ADDR_WIDTH_POW)-1:0] redirect_addr,
    input  logic                           trap_valid,
    input  logic [(1<<ADDR_WIDTH_POW)-1:0] trap_vector,
    input  logic [(1<<ADDR_WIDTH_POW)-1:0] pc_cur_in,
    output logic [(1<<ADDR_WIDTH_POW)-1:0] pc_next_out,
    fetch_sequencer_if.master              bus,
    output logic [31:0]                    fetch_count
);

    localparam int ADDR_WIDTH = 1 << ADDR_WIDTH_POW;

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_REQ  = 2'(REQ);
    localparam logic [1:0] S_WAIT = 2'(WAIT);
    localparam logic [1:0] S_DROP = 2'(DROP);

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic                   started;
    logic                   instr_valid_q;
    logic [INSTR_WIDTH-1:0] instr_data_q;
    logic [ADDR_WIDTH-1:0]  instr_pc_q;
    logic [31:0]            count_q;

    logic                  req_valid;
    logic                  handshake;
    logic                  resp_seen;
    logic                  flush;
    logic                  capture;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [ADDR_WIDTH-1:0] mux_pc;
    next_pc_sel_t          sel;

    // A request only goes out when the buffer is free by the time its response can land.
    assign req_valid = (state == S_REQ) && !stall_in && (!instr_valid_q || bus.instr_ready);
    assign handshake = req_valid && bus.imem_req_ready;
    assign resp_seen = bus.imem_resp_valid && ((state == S_WAIT) || (state == S_DROP));
    assign flush     = (sel == TRAP) || (sel == REDIRECT);
    assign capture   = (state == S_WAIT) && bus.imem_resp_valid && !flush;

    // Before the first fetch after reset the PC register is pinned to the reset vector.
    assign hold_addr = ((state == S_IDLE) && !started) ? RESET_VECTOR : pc_cur_in;

    next_pc_mux #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_next_pc_mux (
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .seq_en         ((state == S_WAIT) && bus.imem_resp_valid),
        .pc_cur         (pc_cur_in),
        .hold_addr      (hold_addr),
        .pc_next        (mux_pc),
        .sel            (sel)
    );

    assign pc_next_out = reset ? mux_pc : RESET_VECTOR;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_cur_in;
    assign bus.instr_valid    = instr_valid_q;
    assign bus.instr_data     = instr_data_q;
    assign bus.instr_pc       = instr_pc_q;
    assign fetch_count        = count_q;

    // Next-state: flushes abandon an in-flight request through DROP, otherwise restart at REQ.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (flush || run_in) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (handshake)                    state_nxt = flush ? S_DROP : S_WAIT;
                else if (flush)                   state_nxt = S_REQ;
                else if (!run_in && !req_valid)   state_nxt = S_IDLE;
            end
            S_WAIT: begin
                if (flush)          state_nxt = resp_seen ? S_REQ : S_DROP;
                else if (resp_seen) state_nxt = run_in ? S_REQ : S_IDLE;
            end
            S_DROP: begin
                if (resp_seen) state_nxt = (run_in || flush) ? S_REQ : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state and the "fetched since reset" flag.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= started || (state_nxt != S_IDLE);
        end
    end

    // One-entry decode buffer: flush beats capture, capture beats drain.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
        end else if (flush) begin
            instr_valid_q <= 1'b0;
        end else if (capture) begin
            instr_valid_q <= 1'b1;
            instr_data_q  <= bus.imem_resp_data;
            instr_pc_q    <= pc_cur_in;
        end else if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
        end
    end

    // Delivered-instruction counter; a flushed cycle delivers nothing.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (instr_valid_q && bus.instr_ready && !flush) begin
            count_q <= count_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC register model and a fixed-latency memory responder.
// Latency: responder answers lat cycles after an accepted request.
// Backpressure: decode readiness and stall driven per scenario.
module tb_fetch_sequencer;

    localparam logic [63:0] RV = 64'h0;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        run_in;
    logic        stall_in;
    logic        redirect_valid;
    logic [63:0] redirect_addr;
    logic        trap_valid;
    logic [63:0] trap_vector;
    logic [63:0] pc_cur_in;
    logic [63:0] pc_next_out;
    logic [31:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;

    fetch_sequencer_if #(.ADDR_WIDTH(64)) bus ();

    fetch_sequencer #(
        .ADDR_WIDTH_POW (6),
        .RESET_VECTOR   (RV),
        .INSTR_BYTES    (4)
    ) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .run_in         (run_in),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .pc_cur_in      (pc_cur_in),
        .pc_next_out    (pc_next_out),
        .bus            (bus.master),
        .fetch_count    (fetch_count)
    );

    always #5 clk_in = ~clk_in;

    // External PC register: plain synchronous load of pc_next_out.
    always @(posedge clk_in) pc_cur_in <= pc_next_out;

    function automatic logic [31:0] mk(input logic [63:0] a);
        return 32'hC0DE_0000 ^ a[31:0];
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic reset_and_run();
        reset          = 1'b0;
        run_in         = 1'b0;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        trap_valid     = 1'b0;
        bus.instr_ready = 1'b1;
        lat            = 1;
        repeat (4) step();
        reset  = 1'b1;
        run_in = 1'b1;
    endtask

    // Memory responder: latches an accepted request mid-cycle, answers lat cycles later for one cycle.
    initial begin
        logic        pend;
        int          cnt;
        logic [63:0] paddr;
        pend = 1'b0;
        cnt  = 0;
        paddr = '0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(negedge clk_in);
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = bus.imem_req_addr;
            end
            @(posedge clk_in);
            #1;
            bus.imem_resp_valid = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mk(paddr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b0;
        run_in         = 1'b0;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        trap_valid     = 1'b0;
        trap_vector    = '0;
        bus.instr_ready    = 1'b1;
        bus.imem_req_ready = 1'b1;
        repeat (2) step();

        // Reset values
        check_eq("rst_pc_next",   pc_next_out, RV);
        check_eq("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        check_eq("rst_instr_vld", {63'd0, bus.instr_valid}, 64'd0);
        check_eq("rst_instr_dat", {32'd0, bus.instr_data}, 64'd0);
        check_eq("rst_instr_pc",  bus.instr_pc, 64'd0);
        check_eq("rst_count",     {32'd0, fetch_count}, 64'd0);

        // Sequential fetch, 1-cycle memory latency
        reset  = 1'b1;
        run_in = 1'b1;
        #1 check_eq("idle_pc_next", pc_next_out, RV);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("seq_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
            check_eq("seq_req_addr",  bus.imem_req_addr, 64'(i * 4));
            if (i > 0) begin
                check_eq("seq_instr_pc",  bus.instr_pc, 64'((i - 1) * 4));
                check_eq("seq_instr_dat", {32'd0, bus.instr_data}, {32'd0, mk(64'((i - 1) * 4))});
            end
            step();
            check_eq("seq_pc_next", pc_next_out, 64'(i * 4 + 4));
        end
        step();
        check_eq("seq_instr_pc2", bus.instr_pc, 64'd8);
        step();
        check_eq("seq_count3", {32'd0, fetch_count}, 64'd3);

        // Decode back-pressure with a full buffer
        reset_and_run();
        bus.instr_ready = 1'b0;
        step();
        step();
        step();
        check_eq("bp_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        check_eq("bp_pc_hold",   pc_next_out, 64'h4);
        step();
        step();
        check_eq("bp_req_valid2", {63'd0, bus.imem_req_valid}, 64'd0);
        check_eq("bp_pc_hold2",   pc_next_out, 64'h4);
        check_eq("bp_instr_vld",  {63'd0, bus.instr_valid}, 64'd1);
        bus.instr_ready = 1'b1;
        #1;
        check_eq("bp_rel_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        check_eq("bp_rel_addr",  bus.imem_req_addr, 64'h4);
        step();
        check_eq("bp_count", {32'd0, fetch_count}, 64'd1);

        // Redirect while waiting: the late response must be dropped
        reset_and_run();
        lat = 3;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 64'h100;
        #1 check_eq("rd_pc_next", pc_next_out, 64'h100);
        step();
        redirect_valid = 1'b0;
        check_eq("rd_drop_noreq", {63'd0, bus.imem_req_valid}, 64'd0);
        check_eq("rd_drop_pc",    pc_next_out, 64'h100);
        step();
        check_eq("rd_drop_vld",   {63'd0, bus.instr_valid}, 64'd0);
        check_eq("rd_drop_pc2",   pc_next_out, 64'h100);
        step();
        check_eq("rd_req_valid",  {63'd0, bus.imem_req_valid}, 64'd1);
        check_eq("rd_req_addr",   bus.imem_req_addr, 64'h100);
        check_eq("rd_instr_vld",  {63'd0, bus.instr_valid}, 64'd0);
        check_eq("rd_count",      {32'd0, fetch_count}, 64'd0);

        // Trap and redirect together: trap wins and the buffer flushes
        reset_and_run();
        bus.instr_ready = 1'b0;
        step();
        step();
        step();
        check_eq("tr_instr_vld_pre", {63'd0, bus.instr_valid}, 64'd1);
        trap_valid     = 1'b1;
        trap_vector    = 64'h200;
        redirect_valid = 1'b1;
        redirect_addr  = 64'h100;
        #1 check_eq("tr_pc_next", pc_next_out, 64'h200);
        step();
        trap_valid     = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check_eq("tr_instr_vld", {63'd0, bus.instr_valid}, 64'd0);
        check_eq("tr_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        check_eq("tr_req_addr",  bus.imem_req_addr, 64'h200);
        check_eq("tr_count",     {32'd0, fetch_count}, 64'd0);

        // Stall in REQ for five cycles
        reset_and_run();
        step();
        step();
        step();
        stall_in = 1'b1;
        #1 check_eq("st_req_valid0", {63'd0, bus.imem_req_valid}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("st_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
            check_eq("st_pc_hold",   pc_next_out, 64'h4);
        end
        stall_in = 1'b0;
        #1;
        check_eq("st_rel_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        check_eq("st_rel_addr",  bus.imem_req_addr, 64'h4);

        // Redirect from IDLE to the top of the address space; increment wraps
        reset_and_run();
        redirect_valid = 1'b1;
        redirect_addr  = 64'hFFFF_FFFF_FFFF_FFFC;
        #1 check_eq("wr_pc_next", pc_next_out, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        redirect_valid = 1'b0;
        check_eq("wr_req_addr", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check_eq("wr_pc_wrap", pc_next_out, 64'h0);

        // Asynchronous reset while a response is outstanding
        reset_and_run();
        step();
        step();
        step();
        lat = 3;
        step();
        check_eq("ar_count_pre", {32'd0, fetch_count}, 64'd1);
        reset = 1'b0;
        #1;
        check_eq("ar_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        check_eq("ar_instr_vld", {63'd0, bus.instr_valid}, 64'd0);
        check_eq("ar_instr_dat", {32'd0, bus.instr_data}, 64'd0);
        check_eq("ar_count",     {32'd0, fetch_count}, 64'd0);
        check_eq("ar_pc_next",   pc_next_out, RV);
        repeat (4) step();
        reset  = 1'b1;
        run_in = 1'b1;
        lat    = 1;
        #1 check_eq("ar_rel_vld", {63'd0, bus.instr_valid}, 64'd0);
        step();
        check_eq("ar_req_valid2", {63'd0, bus.imem_req_valid}, 64'd1);
        check_eq("ar_req_addr",   bus.imem_req_addr, RV);
        check_eq("ar_instr_vld2", {63'd0, bus.instr_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
